// File: rtl/arm_fetch_unit.sv
// Instruction-fetch stage for the single-cycle ARM datapath.
// Owns the PC and sequences sequential fetch, branches, stalls, and IRQ
// entry/return. It also produces PC+4, PC+8 (the R15 read value) and the
// IRQ link value used for the banked LR write.
module arm_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        irq_ret,
  input  logic        nIRQ,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_plus8,
  output logic        fetch_valid,
  output logic        irq_taken,
  output logic [31:0] lr_irq,
  output logic        irq_mask
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    IRQ_ENTRY
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        sync1;
  logic        sync2;
  logic        irq_req;
  logic [31:0] target;
  logic [31:0] pc_next;
  logic [31:0] lr_next;
  logic        mask_next;
  logic        unused_target_lsbs;

  // Word-aligned branch target; the low two bits are discarded.
  assign target             = {branch_target[31:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];

  assign pc_plus4 = pc + 32'd4;
  assign pc_plus8 = pc + 32'd8;
  assign irq_req  = ~sync2;

  // Two-flop synchronizer for the asynchronous active-low IRQ pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= nIRQ;
      sync2 <= sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-PC selection: stall > IRQ > branch > sequential.
  // When an IRQ wins over a same-cycle branch, the branch target is folded
  // into the link value so the branch is taken on return.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    lr_next    = lr_irq;
    mask_next  = irq_mask;
    case (state)
      BOOT: begin
        state_next = RUN;
        mask_next  = 1'b0;
      end
      default: begin
        state_next = RUN;
        if (stall) begin
          pc_next = pc;
        end else if (irq_req && !irq_mask) begin
          state_next = IRQ_ENTRY;
          pc_next    = IRQ_VECTOR;
          mask_next  = 1'b1;
          lr_next    = (pc_src ? target : pc_plus4) + 32'd4;
        end else if (pc_src) begin
          pc_next = target;
          if (irq_ret) begin
            mask_next = 1'b0;
          end
        end else begin
          pc_next = pc_plus4;
        end
      end
    endcase
  end

  // PC, link and mask registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_VECTOR;
      lr_irq   <= '0;
      irq_mask <= 1'b1;
    end else begin
      pc       <= pc_next;
      lr_irq   <= lr_next;
      irq_mask <= mask_next;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    fetch_valid = (state != BOOT);
    irq_taken   = (state == IRQ_ENTRY);
  end

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Bench for arm_fetch_unit: directed scenarios against fixed expected
// values, then randomized traffic against a behavioural model.
module tb_arm_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        irq_ret;
  logic        nIRQ;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic        fetch_valid;
  logic        irq_taken;
  logic [31:0] lr_irq;
  logic        irq_mask;

  int checks = 0;
  int errors = 0;

  // Behavioural model: architectural values plus the last two pin samples.
  logic [31:0] m_pc;
  logic [31:0] m_lr;
  bit          m_mask;
  bit          m_boot;
  bit          m_entry;
  bit          samp[2];

  arm_fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .IRQ_VECTOR  (32'h0000_0018)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pc_src       (pc_src),
    .branch_target(branch_target),
    .irq_ret      (irq_ret),
    .nIRQ         (nIRQ),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .pc_plus8     (pc_plus8),
    .fetch_valid  (fetch_valid),
    .irq_taken    (irq_taken),
    .lr_irq       (lr_irq),
    .irq_mask     (irq_mask)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc    = 32'h0;
    m_lr    = 32'h0;
    m_mask  = 1'b1;
    m_boot  = 1'b1;
    m_entry = 1'b0;
    samp[0] = 1'b1;
    samp[1] = 1'b1;
  endtask

  // Drive one cycle of inputs, let one rising edge pass, advance the model.
  task automatic clk_step(input bit s, input bit ps, input logic [31:0] t,
                          input bit ir, input bit n);
    bit          req;
    logic [31:0] nxt;
    stall         = s;
    pc_src        = ps;
    branch_target = t;
    irq_ret       = ir;
    nIRQ          = n;
    req = (samp[1] == 1'b0);
    @(posedge clk);
    #1;
    samp[1] = samp[0];
    samp[0] = n;
    if (m_boot) begin
      m_boot  = 1'b0;
      m_mask  = 1'b0;
      m_entry = 1'b0;
    end else if (s) begin
      m_entry = 1'b0;
    end else if (req && !m_mask) begin
      nxt     = ps ? (t & ~32'h3) : m_pc + 32'd4;
      m_lr    = nxt + 32'd4;
      m_pc    = 32'h18;
      m_mask  = 1'b1;
      m_entry = 1'b1;
    end else begin
      m_entry = 1'b0;
      if (ps) begin
        m_pc = t & ~32'h3;
        if (ir) m_mask = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; pc_src = 1'b0; branch_target = '0;
    irq_ret = 1'b0; nIRQ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", fetch_valid); end
    checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", irq_taken); end
    checks++; if (lr_irq !== 32'h0) begin errors++; $display("FAIL reset_lr got %h exp 0", lr_irq); end
    checks++; if (irq_mask !== 1'b1) begin errors++; $display("FAIL reset_mask got %b exp 1", irq_mask); end
    reset = 1'b1;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_fv got %b exp 0", fetch_valid); end
    clk_step(0, 0, '0, 0, 1);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL boot_pc_held got %h exp 0", pc); end
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL run_fv got %b exp 1", fetch_valid); end
    checks++; if (irq_mask !== 1'b0) begin errors++; $display("FAIL boot_mask got %b exp 0", irq_mask); end
    for (int i = 1; i <= 3; i++) begin
      clk_step(0, 0, '0, 0, 1);
      checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, 32'(4 * i)); end
      checks++; if (pc_plus8 !== 32'(4 * i + 8)) begin errors++; $display("FAIL seq_pc8 got %h exp %h", pc_plus8, 32'(4 * i + 8)); end
    end
  endtask

  task automatic test_branch_stall();
    clk_step(0, 0, '0, 0, 1);
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pre_branch_pc got %h exp 10", pc); end
    clk_step(0, 1, 32'h103, 0, 1);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL branch_pc got %h exp 100", pc); end
    for (int i = 0; i < 3; i++) begin
      clk_step(1, 0, '0, 0, 1);
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL stall_pc got %h exp 100", pc); end
    end
    clk_step(0, 0, '0, 0, 1);
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL post_stall_pc got %h exp 104", pc); end
  endtask

  task automatic test_irq_entry();
    clk_step(0, 1, 32'h20, 0, 1);
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL irq_setup_pc got %h exp 20", pc); end
    clk_step(0, 0, '0, 0, 0);
    checks++; if (pc !== 32'h24 || irq_taken !== 1'b0) begin errors++; $display("FAIL irq_lat1 got pc %h taken %b exp 24 0", pc, irq_taken); end
    clk_step(0, 0, '0, 0, 0);
    checks++; if (pc !== 32'h28 || irq_taken !== 1'b0) begin errors++; $display("FAIL irq_lat2 got pc %h taken %b exp 28 0", pc, irq_taken); end
    clk_step(0, 0, '0, 0, 0);
    checks++; if (pc !== 32'h18) begin errors++; $display("FAIL irq_pc got %h exp 18", pc); end
    checks++; if (irq_taken !== 1'b1) begin errors++; $display("FAIL irq_taken got %b exp 1", irq_taken); end
    checks++; if (lr_irq !== 32'h30) begin errors++; $display("FAIL irq_lr got %h exp 30", lr_irq); end
    checks++; if (irq_mask !== 1'b1) begin errors++; $display("FAIL irq_mask got %b exp 1", irq_mask); end
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL irq_fv got %b exp 1", fetch_valid); end
    clk_step(0, 0, '0, 0, 0);
    checks++; if (pc !== 32'h1C || irq_taken !== 1'b0) begin errors++; $display("FAIL no_reentry1 got pc %h taken %b exp 1c 0", pc, irq_taken); end
    clk_step(0, 0, '0, 0, 0);
    checks++; if (pc !== 32'h20 || irq_taken !== 1'b0) begin errors++; $display("FAIL no_reentry2 got pc %h taken %b exp 20 0", pc, irq_taken); end
  endtask

  task automatic test_return_reentry();
    clk_step(0, 1, 32'h2C, 1, 0);
    checks++; if (pc !== 32'h2C || irq_mask !== 1'b0 || irq_taken !== 1'b0) begin errors++; $display("FAIL ret_edge got pc %h mask %b taken %b exp 2c 0 0", pc, irq_mask, irq_taken); end
    clk_step(0, 0, '0, 0, 0);
    checks++; if (pc !== 32'h18 || irq_taken !== 1'b1) begin errors++; $display("FAIL reentry got pc %h taken %b exp 18 1", pc, irq_taken); end
    checks++; if (lr_irq !== 32'h34) begin errors++; $display("FAIL reentry_lr got %h exp 34", lr_irq); end
  endtask

  task automatic test_irq_branch();
    clk_step(0, 1, 32'h40, 1, 0);
    checks++; if (pc !== 32'h40 || irq_mask !== 1'b0) begin errors++; $display("FAIL ib_ret got pc %h mask %b exp 40 0", pc, irq_mask); end
    clk_step(0, 1, 32'h200, 0, 0);
    checks++; if (pc !== 32'h18 || irq_taken !== 1'b1) begin errors++; $display("FAIL ib_pc got pc %h taken %b exp 18 1", pc, irq_taken); end
    checks++; if (lr_irq !== 32'h204) begin errors++; $display("FAIL ib_lr got %h exp 204", lr_irq); end
    clk_step(0, 0, '0, 0, 1);
    clk_step(0, 0, '0, 0, 1);
    clk_step(0, 1, 32'h204, 1, 1);
    checks++; if (pc !== 32'h204 || irq_mask !== 1'b0) begin errors++; $display("FAIL ib_return got pc %h mask %b exp 204 0", pc, irq_mask); end
    clk_step(0, 0, '0, 0, 1);
    checks++; if (pc !== 32'h208 || irq_taken !== 1'b0) begin errors++; $display("FAIL ib_after got pc %h taken %b exp 208 0", pc, irq_taken); end
  endtask

  task automatic test_wrap();
    clk_step(0, 1, 32'hFFFF_FFFE, 0, 1);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", pc); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", pc_plus4); end
    checks++; if (pc_plus8 !== 32'h4) begin errors++; $display("FAIL wrap_pc8 got %h exp 4", pc_plus8); end
    clk_step(0, 0, '0, 0, 1);
    checks++; if (pc !== 32'h0 || pc_plus8 !== 32'h8) begin errors++; $display("FAIL wrap_next got pc %h pc8 %h exp 0 8", pc, pc_plus8); end
  endtask

  task automatic test_random();
    bit          s;
    bit          ps;
    bit          ir;
    bit          n;
    logic [31:0] t;
    n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom % 8) == 0;
      ps = !s && (($urandom % 4) == 0);
      ir = ps && (($urandom % 2) == 0);
      t  = $urandom;
      if (($urandom % 6) == 0) n = ~n;
      clk_step(s, ps, t, ir, n);
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, pc, m_pc); end
      checks++; if (pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4 cyc %0d got %h exp %h", i, pc_plus4, m_pc + 32'd4); end
      checks++; if (pc_plus8 !== m_pc + 32'd8) begin errors++; $display("FAIL rnd_pc8 cyc %0d got %h exp %h", i, pc_plus8, m_pc + 32'd8); end
      checks++; if (irq_taken !== m_entry) begin errors++; $display("FAIL rnd_taken cyc %0d got %b exp %b", i, irq_taken, m_entry); end
      checks++; if (fetch_valid !== !m_boot) begin errors++; $display("FAIL rnd_fv cyc %0d got %b exp %b", i, fetch_valid, !m_boot); end
      checks++; if (lr_irq !== m_lr) begin errors++; $display("FAIL rnd_lr cyc %0d got %h exp %h", i, lr_irq, m_lr); end
      checks++; if (irq_mask !== m_mask) begin errors++; $display("FAIL rnd_mask cyc %0d got %b exp %b", i, irq_mask, m_mask); end
    end
  endtask

  task automatic test_async_reset();
    clk_step(0, 0, '0, 0, 1);
    clk_step(0, 0, '0, 0, 1);
    clk_step(0, 1, 32'h300, 1, 1);
    checks++; if (pc !== 32'h300 || irq_mask !== 1'b0) begin errors++; $display("FAIL ar_setup got pc %h mask %b exp 300 0", pc, irq_mask); end
    clk_step(0, 0, '0, 0, 0);
    clk_step(0, 0, '0, 0, 0);
    clk_step(0, 0, '0, 0, 0);
    checks++; if (pc !== 32'h18 || irq_taken !== 1'b1) begin errors++; $display("FAIL ar_entry got pc %h taken %b exp 18 1", pc, irq_taken); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL ar_pc got %h exp 0", pc); end
    checks++; if (fetch_valid !== 1'b0 || irq_taken !== 1'b0) begin errors++; $display("FAIL ar_flags got fv %b taken %b exp 0 0", fetch_valid, irq_taken); end
    checks++; if (lr_irq !== 32'h0 || irq_mask !== 1'b1) begin errors++; $display("FAIL ar_lr_mask got lr %h mask %b exp 0 1", lr_irq, irq_mask); end
    model_reset();
    reset = 1'b1;
    clk_step(0, 0, '0, 0, 1);
    checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL ar_boot got pc %h fv %b exp 0 1", pc, fetch_valid); end
    clk_step(0, 0, '0, 0, 1);
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL ar_seq got %h exp 4", pc); end
  endtask

  initial begin
    test_reset();
    test_branch_stall();
    test_irq_entry();
    test_return_reentry();
    test_irq_branch();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
